// File: rtl/uart_ram_loader_pkg.sv
// Shared types and constants for the UART-to-RAM image loader.
// Holds the loader FSM states, the error codes and the frame start marker.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_L,
        ST_ADDR_H,
        ST_LEN_L,
        ST_LEN_H,
        ST_DATA,
        ST_CSUM,
        ST_RELEASE
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // The lowest 16K of the Z80 map is ROM and must never see a write strobe.
    function automatic logic is_rom(input logic [15:0] addr);
        return addr[15:14] == 2'b00;
    endfunction

endpackage

// File: rtl/uart_ram_loader_if.sv
// Signal bundle between the loader, the UART receive strobe, the RAM write port
// and the CPU bus request/acknowledge pins.
interface uart_ram_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busak_n;
    logic        busrq_n;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_we;
    logic        active;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    modport slave (
        input  rx_data, rx_valid, busak_n,
        output busrq_n, mem_addr, mem_dout, mem_we, active, done, err, err_code
    );

    modport master (
        output rx_data, rx_valid, busak_n,
        input  busrq_n, mem_addr, mem_dout, mem_we, active, done, err, err_code
    );
endinterface

// File: rtl/uart_ram_loader_timeout.sv
// Inter-byte watchdog: counts idle clocks while enabled and flags expiry
// once TIMEOUT cycles have passed since the last restart.
module loader_timeout #(
    parameter int TIMEOUT   = 1000000,
    parameter int TIMEOUT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);
    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

    logic [TIMEOUT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!enable || restart) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign expired = enable && (count == LIMIT);
endmodule

// File: rtl/uart_ram_loader.sv
// Receives a framed image over the UART byte strobe and writes it into the
// Z80 map, holding the CPU off the bus with BUSRQ while writing.
module uart_ram_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT   = 1000000,
    parameter int         TIMEOUT_W = 20
) (
    input logic               clk,
    input logic               rst,
    uart_ram_loader_if.slave  bus
);
    state_e      state;
    logic [15:0] addr;
    logic [15:0] remain;
    logic [7:0]  hold;
    logic        pending;
    logic [7:0]  csum;
    logic        busrq_n;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_we;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        expired;

    logic        granted;
    logic        take;
    logic        issue;
    logic [7:0]  wr_byte;

    loader_timeout #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .restart (bus.rx_valid),
        .enable  (state != ST_IDLE && state != ST_RELEASE),
        .expired (expired)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        granted = !bus.busak_n;
        take    = bus.rx_valid && (remain != 16'h0000);
        issue   = granted && (pending || take);
        wr_byte = pending ? hold : bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            remain   <= '0;
            hold     <= '0;
            pending  <= 1'b0;
            csum     <= '0;
            busrq_n  <= 1'b1;
            mem_addr <= '0;
            mem_dout <= '0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (expired) begin
                // Expiry outranks a byte arriving in the same cycle.
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
                pending  <= 1'b0;
                busrq_n  <= 1'b1;
                state    <= ST_RELEASE;
            end else begin
                case (state)
                    ST_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        csum     <= '0;
                        busrq_n  <= 1'b0;
                        state    <= ST_ADDR_L;
                    end
                    ST_ADDR_L: if (bus.rx_valid) begin
                        addr[7:0] <= bus.rx_data;
                        state     <= ST_ADDR_H;
                    end
                    ST_ADDR_H: if (bus.rx_valid) begin
                        addr[15:8] <= bus.rx_data;
                        state      <= ST_LEN_L;
                    end
                    ST_LEN_L: if (bus.rx_valid) begin
                        remain[7:0] <= bus.rx_data;
                        state       <= ST_LEN_H;
                    end
                    ST_LEN_H: if (bus.rx_valid) begin
                        remain[15:8] <= bus.rx_data;
                        pending      <= 1'b0;
                        state        <= ({bus.rx_data, remain[7:0]} == 16'h0000) ? ST_CSUM : ST_DATA;
                    end
                    ST_DATA: begin
                        if (take && pending && !granted) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVERRUN;
                            pending  <= 1'b0;
                            busrq_n  <= 1'b1;
                            state    <= ST_RELEASE;
                        end else begin
                            // ROM-bound bytes still consume an address slot.
                            if (issue) begin
                                mem_we   <= !is_rom(addr);
                                mem_addr <= addr;
                                mem_dout <= wr_byte;
                                addr     <= addr + 16'd1;
                            end
                            if (take) begin
                                csum   <= csum ^ bus.rx_data;
                                remain <= remain - 16'd1;
                            end
                            if (take && (pending || !granted)) begin
                                hold    <= bus.rx_data;
                                pending <= 1'b1;
                            end else if (granted) begin
                                pending <= 1'b0;
                            end
                            if (remain == 16'h0000 && !pending) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: if (bus.rx_valid) begin
                        if (bus.rx_data == csum) begin
                            done <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                        busrq_n <= 1'b1;
                        state   <= ST_RELEASE;
                    end
                    ST_RELEASE: begin
                        busrq_n <= 1'b1;
                        if (bus.busak_n) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busrq_n  = busrq_n;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_dout = mem_dout;
    assign bus.mem_we   = mem_we;
    assign bus.active   = (state != ST_IDLE);
    assign bus.done     = done;
    assign bus.err      = err;
    assign bus.err_code = err_code;
endmodule
